// File: rtl/ser_pkg.sv
// Shared types and parameter checks for the wide-to-narrow serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_SHIFT
  } ser_state_t;

  // IN_W must split into at least two whole slices; DEPTH must be a power of 2, >= 2.
  function automatic bit widths_ok(input int in_w, input int out_w, input int depth);
    return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2)
        && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/wide_to_narrow_serializer_if.sv
// Producer/consumer signal bundle of the wide-to-narrow serializer.
interface wide_to_narrow_serializer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             strobe_in;
  logic [IN_W-1:0]  input_data;
  logic             full;
  logic             overflow;
  logic [LVL_W-1:0] level;
  logic             req_data;
  logic             ready;
  logic             strobe_out;
  logic [OUT_W-1:0] data_out;
  logic             data_end;

  modport master (
    output strobe_in, input_data, req_data,
    input  full, overflow, level, ready, strobe_out, data_out, data_end
  );

  modport slave (
    input  strobe_in, input_data, req_data,
    output full, overflow, level, ready, strobe_out, data_out, data_end
  );
endinterface

// File: rtl/ser_word_fifo.sv
// Word FIFO for the serializer: W x DEPTH, pointers carry an extra wrap bit.
module ser_word_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           wr_data,
  input  logic                   pop,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok;
  logic         pop_ok;

  // Same index with opposite wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; cleared pointers already make every entry invisible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/wide_to_narrow_serializer.sv
// Buffers IN_W-bit words and emits them as OUT_W-bit slices on request.
// Define MSB_FIRST_EN to emit the most significant slice first (default is LSB-first).
module wide_to_narrow_serializer
  import ser_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  wide_to_narrow_serializer_if.slave  bus
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTH);

  if (!widths_ok(IN_W, OUT_W, DEPTH)) begin : g_param_check
    $error("wide_to_narrow_serializer: illegal IN_W/OUT_W/DEPTH combination");
  end

  ser_state_t       state_q, state_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0] slice_idx_q, slice_idx_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic             strobe_out_q, strobe_out_d;
  logic             data_end_q, data_end_d;
  logic             overflow_q, overflow_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IN_W-1:0]  fifo_rd_data;
  logic [AW:0]      fifo_level;

  logic [OUT_W-1:0] slices [RATIO];
  logic [OUT_W-1:0] cur_slice;
  logic             last_slice;

  ser_word_fifo #(
    .W     (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.strobe_in),
    .wr_data (bus.input_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
`ifdef MSB_FIRST_EN
    assign slices[i] = word_q[IN_W-1-i*OUT_W -: OUT_W];
`else
    assign slices[i] = word_q[i*OUT_W +: OUT_W];
`endif
  end

  assign cur_slice  = slices[slice_idx_q];
  assign last_slice = (slice_idx_q == IDX_W'(RATIO - 1));

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    slice_idx_d  = slice_idx_q;
    data_out_d   = data_out_q;
    strobe_out_d = 1'b0;
    data_end_d   = 1'b0;
    fifo_pop     = 1'b0;
    // The FIFO ignores a push while full, so a drop is reported even if a pop frees a slot.
    overflow_d   = bus.strobe_in && fifo_full;

    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          word_d      = fifo_rd_data;
          slice_idx_d = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.req_data) begin
          strobe_out_d = 1'b1;
          data_out_d   = cur_slice;
          data_end_d   = last_slice;
          if (last_slice) begin
            slice_idx_d = '0;
            // Reload on the final slice's edge keeps the slice stream gap-free.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              word_d   = fifo_rd_data;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            slice_idx_d = slice_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      word_q       <= '0;
      slice_idx_q  <= '0;
      data_out_q   <= '0;
      strobe_out_q <= 1'b0;
      data_end_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      slice_idx_q  <= slice_idx_d;
      data_out_q   <= data_out_d;
      strobe_out_q <= strobe_out_d;
      data_end_q   <= data_end_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.full       = fifo_full;
  assign bus.overflow   = overflow_q;
  assign bus.level      = fifo_level;
  assign bus.ready      = (state_q == ST_SHIFT);
  assign bus.strobe_out = strobe_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_end   = data_end_q;

endmodule

// File: tb/tb_wide_to_narrow_serializer.sv
// Randomized self-checking bench for wide_to_narrow_serializer against a slice-stream model.
module tb_wide_to_narrow_serializer;
  localparam int IN_W   = 64;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 4;
  localparam int RATIO  = IN_W / OUT_W;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int OUTS_W = LVL_W + OUT_W + 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  wide_to_narrow_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  wide_to_narrow_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [IN_W-1:0]  wr_q[$];
  logic [OUT_W-1:0] got_data[$];
  logic [OUT_W-1:0] exp_data[$];
  logic             got_end[$];
  logic             exp_end[$];
  int n_strobe, n_bad_grant, n_ovf, first_cyc, last_cyc, cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word becomes RATIO slices, the last one flagged.
  function automatic void add_expected(input logic [IN_W-1:0] w);
    for (int i = 0; i < RATIO; i++) begin
`ifdef MSB_FIRST_EN
      exp_data.push_back(OUT_W'(w >> (IN_W - OUT_W * (i + 1))));
`else
      exp_data.push_back(OUT_W'(w >> (OUT_W * i)));
`endif
      exp_end.push_back(i == RATIO - 1);
    end
  endfunction

  function automatic void clear_capture();
    wr_q.delete();
    got_data.delete();
    got_end.delete();
    exp_data.delete();
    exp_end.delete();
    n_strobe    = 0;
    n_bad_grant = 0;
    n_ovf       = 0;
    first_cyc   = 0;
    last_cyc    = 0;
    cyc         = 0;
  endfunction

  function automatic logic [IN_W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [OUTS_W-1:0] outs();
    return {bus.full, bus.overflow, bus.level, bus.ready, bus.strobe_out, bus.data_out, bus.data_end};
  endfunction

  // Drives queued writes one per cycle and records emitted slices; req_mode 0=low 1=high 2=toggle 3=random.
  task automatic run(input int req_mode, input int max_cycles, input bit stop_idle);
    logic granted;
    for (int c = 0; c < max_cycles; c++) begin
      if (wr_q.size() > 0) begin
        bus.strobe_in  = 1'b1;
        bus.input_data = wr_q.pop_front();
      end else begin
        bus.strobe_in = 1'b0;
      end
      case (req_mode)
        0:       bus.req_data = 1'b0;
        1:       bus.req_data = 1'b1;
        2:       bus.req_data = ~bus.req_data;
        default: bus.req_data = 1'($urandom_range(0, 1));
      endcase
      granted = bus.req_data & bus.ready;
      step();
      cyc++;
      if (bus.strobe_out !== granted) n_bad_grant++;
      if (bus.overflow === 1'b1) n_ovf++;
      if (bus.strobe_out === 1'b1) begin
        got_data.push_back(bus.data_out);
        got_end.push_back(bus.data_end);
        if (n_strobe == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_strobe++;
      end
      if (stop_idle && wr_q.size() == 0 && bus.ready === 1'b0 && bus.level == '0) break;
    end
    bus.strobe_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.strobe_in  = 1'b0;
    bus.req_data   = 1'b0;
    bus.input_data = '0;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.strobe_in  = 1'($urandom_range(0, 1));
      bus.req_data   = 1'($urandom_range(0, 1));
      bus.input_data = rand_word();
      step();
      vectors++;
      if (outs() !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %h, expected 0", i, outs());
      end
    end
    bus.strobe_in = 1'b0;
    bus.req_data  = 1'b0;
    reset_n       = 1'b1;
    step();
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got %h, expected 0", outs());
    end
  endtask

  task automatic test_single_word();
    logic [IN_W-1:0] w;
    clear_capture();
    w = 64'h0807060504030201;
    add_expected(w);
    bus.req_data   = 1'b1;
    bus.strobe_in  = 1'b1;
    bus.input_data = w;
    step();
    vectors++;
    if (bus.level !== LVL_W'(1) || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after_write: got level=%0d ready=%b, expected level=1 ready=0", bus.level, bus.ready);
    end
    bus.strobe_in = 1'b0;
    step();
    vectors++;
    if (bus.level !== LVL_W'(0) || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_after_load: got level=%0d ready=%b, expected level=0 ready=1", bus.level, bus.ready);
    end
    run(1, 20, 1'b1);
    vectors++;
    if (n_bad_grant != 0 || last_cyc - first_cyc + 1 != RATIO) begin
      miscompares++;
      $display("FAIL single_timing: got bad_grant=%0d span=%0d, expected 0 and %0d", n_bad_grant, last_cyc - first_cyc + 1, RATIO);
    end
    vectors++;
    if (got_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL single_count: got %0d slices, expected %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      vectors++;
      if (i >= got_data.size()) begin
        miscompares++;
        $display("FAIL single_slice[%0d]: missing, expected %h", i, exp_data[i]);
      end else if ({got_data[i], got_end[i]} !== {exp_data[i], exp_end[i]}) begin
        miscompares++;
        $display("FAIL single_slice[%0d]: got %h end=%b, expected %h end=%b", i, got_data[i], got_end[i], exp_data[i], exp_end[i]);
      end
    end
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready_drop: got %b, expected 0", bus.ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [IN_W-1:0] w;
    clear_capture();
    for (int i = 0; i < 5; i++) begin
      w = rand_word();
      wr_q.push_back(w);
      add_expected(w);
    end
    run(1, 80, 1'b1);
    vectors++;
    if (n_bad_grant != 0 || n_ovf != 0 || last_cyc - first_cyc + 1 != exp_data.size()) begin
      miscompares++;
      $display("FAIL b2b_contiguous: got bad_grant=%0d ovf=%0d span=%0d, expected 0 0 %0d", n_bad_grant, n_ovf, last_cyc - first_cyc + 1, exp_data.size());
    end
    vectors++;
    if (got_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d slices, expected %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      vectors++;
      if (i >= got_data.size()) begin
        miscompares++;
        $display("FAIL b2b_slice[%0d]: missing, expected %h", i, exp_data[i]);
      end else if ({got_data[i], got_end[i]} !== {exp_data[i], exp_end[i]}) begin
        miscompares++;
        $display("FAIL b2b_slice[%0d]: got %h end=%b, expected %h end=%b", i, got_data[i], got_end[i], exp_data[i], exp_end[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [IN_W-1:0] w;
    clear_capture();
    // One word in the stage plus DEPTH in the FIFO are kept; the next write is dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = rand_word();
      wr_q.push_back(w);
      if (i < DEPTH + 1) add_expected(w);
    end
    run(0, DEPTH + 4, 1'b0);
    vectors++;
    if (bus.level !== LVL_W'(DEPTH) || bus.full !== 1'b1 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_fill: got level=%0d full=%b ready=%b, expected %0d 1 1", bus.level, bus.full, bus.ready, DEPTH);
    end
    vectors++;
    if (n_ovf != 1 || n_strobe != 0) begin
      miscompares++;
      $display("FAIL ovf_pulse: got overflow_cycles=%0d strobes=%0d, expected 1 0", n_ovf, n_strobe);
    end
    run(1, 80, 1'b1);
    vectors++;
    if (n_bad_grant != 0 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_drain: got bad_grant=%0d full=%b, expected 0 0", n_bad_grant, bus.full);
    end
    vectors++;
    if (got_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d slices, expected %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      vectors++;
      if (i >= got_data.size()) begin
        miscompares++;
        $display("FAIL ovf_slice[%0d]: missing, expected %h", i, exp_data[i]);
      end else if ({got_data[i], got_end[i]} !== {exp_data[i], exp_end[i]}) begin
        miscompares++;
        $display("FAIL ovf_slice[%0d]: got %h end=%b, expected %h end=%b", i, got_data[i], got_end[i], exp_data[i], exp_end[i]);
      end
    end
  endtask

  task automatic test_req_pattern(input int req_mode, input int n_words);
    logic [IN_W-1:0] w;
    clear_capture();
    bus.req_data = 1'b0;
    for (int i = 0; i < n_words; i++) begin
      w = rand_word();
      wr_q.push_back(w);
      add_expected(w);
    end
    run(req_mode, 300, 1'b1);
    vectors++;
    if (n_bad_grant != 0 || n_strobe != exp_data.size()) begin
      miscompares++;
      $display("FAIL req_mode%0d_grants: got bad_grant=%0d strobes=%0d, expected 0 %0d", req_mode, n_bad_grant, n_strobe, exp_data.size());
    end
    foreach (exp_data[i]) begin
      vectors++;
      if (i >= got_data.size()) begin
        miscompares++;
        $display("FAIL req_mode%0d_slice[%0d]: missing, expected %h", req_mode, i, exp_data[i]);
      end else if ({got_data[i], got_end[i]} !== {exp_data[i], exp_end[i]}) begin
        miscompares++;
        $display("FAIL req_mode%0d_slice[%0d]: got %h end=%b, expected %h end=%b", req_mode, i, got_data[i], got_end[i], exp_data[i], exp_end[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [IN_W-1:0] w;
    clear_capture();
    w = rand_word();
    wr_q.push_back(w);
    add_expected(w);
    // Write, load, then three granted slices.
    run(1, 5, 1'b0);
    vectors++;
    if (n_strobe != 3 || got_data.size() != 3 || got_data[2] !== exp_data[2]) begin
      miscompares++;
      $display("FAIL midrst_prefix: got %0d slices, expected 3 ending with %h", n_strobe, exp_data[2]);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL midrst_immediate: got %h, expected 0", outs());
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    vectors++;
    if (bus.ready !== 1'b0 || bus.level !== LVL_W'(0) || outs() !== '0) begin
      miscompares++;
      $display("FAIL midrst_release: got ready=%b level=%0d outs=%h, expected all 0", bus.ready, bus.level, outs());
    end
    clear_capture();
    w = rand_word();
    wr_q.push_back(w);
    add_expected(w);
    run(1, 20, 1'b1);
    vectors++;
    if (got_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL midrst_count: got %0d slices, expected %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      vectors++;
      if (i >= got_data.size()) begin
        miscompares++;
        $display("FAIL midrst_slice[%0d]: missing, expected %h", i, exp_data[i]);
      end else if ({got_data[i], got_end[i]} !== {exp_data[i], exp_end[i]}) begin
        miscompares++;
        $display("FAIL midrst_slice[%0d]: got %h end=%b, expected %h end=%b", i, got_data[i], got_end[i], exp_data[i], exp_end[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.strobe_in  = 1'b0;
    bus.req_data   = 1'b0;
    bus.input_data = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_req_pattern(2, 2);
    test_req_pattern(3, 3);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
